// File: rtl/dma_rsp_router_pkg.sv
// Shared DMA definitions: channel count, index width helper, tracking entry width.
package dma_rsp_router_pkg;

  localparam int unsigned CH_NUM    = 4;
  localparam int unsigned DMA_LEN_W = 8;

  // Bits needed to encode a channel index; never less than one.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width of one tracking entry {channel index, beats-1}.
  function automatic int unsigned trk_entry_w(input int unsigned ch_num, input int unsigned len_w);
    return ch_idx_w(ch_num) + len_w;
  endfunction

  localparam int unsigned TRK_ENTRY_W = trk_entry_w(CH_NUM, DMA_LEN_W);

endpackage

// File: rtl/dma_rsp_router_fifo.sv
// Synchronous FIFO holding the in-order list of outstanding bursts.
module sync_fifo #(
  parameter int unsigned W     = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Entry storage; contents need no reset since count qualifies them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally modulo DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dma_rsp_router.sv
// Routes in-order bus read responses back to the DMA channel that issued each burst.
module dma_rsp_router
  import dma_rsp_router_pkg::*;
#(
  parameter int unsigned CH_NUM = dma_rsp_router_pkg::CH_NUM,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     issue_vld,
  input  logic [CH_NUM-1:0]        issue_gnt,
  input  logic [LEN_W-1:0]         issue_len,
  output logic                     issue_rdy,
  input  logic                     rsp_vld,
  input  logic [DATA_W-1:0]        rsp_data,
  input  logic                     rsp_last,
  output logic                     rsp_rdy,
  output logic [CH_NUM-1:0]        ch_rsp_vld,
  output logic [DATA_W-1:0]        ch_rsp_data,
  output logic                     ch_rsp_last,
  input  logic [CH_NUM-1:0]        ch_rsp_rdy,
  output logic                     err_len,
  output logic [$clog2(DEPTH):0]   outstanding
);

  localparam int unsigned CH_IDX_W = ch_idx_w(CH_NUM);
  localparam int unsigned ENTRY_W  = trk_entry_w(CH_NUM, LEN_W);

  logic [CH_IDX_W-1:0] gnt_idx;
  logic                gnt_onehot;
  logic                push;
  logic                pop;
  logic [ENTRY_W-1:0]  head_entry;
  logic [CH_IDX_W-1:0] head_ch;
  logic [LEN_W-1:0]    head_len;
  logic                fifo_full;
  logic                fifo_empty;
  logic [LEN_W-1:0]    beat_cnt;
  logic                beat_acc;
  logic                burst_done;
  logic                err_set;

  // Encode the grant vector; one-hot legality is checked separately.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < int'(CH_NUM); i++) begin
      if (issue_gnt[i]) begin
        gnt_idx = CH_IDX_W'(i);
      end
    end
  end

  assign gnt_onehot = (|issue_gnt) && ((issue_gnt & (issue_gnt - CH_NUM'(1))) == '0);

  // Ready depends only on fullness, so a same-cycle pop never frees a slot early.
  assign issue_rdy = !fifo_full;
  assign push      = issue_vld && gnt_onehot && !fifo_full;

  sync_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_trk_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data ({gnt_idx, issue_len}),
    .pop       (pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding)
  );

  assign head_len = head_entry[LEN_W-1:0];
  assign head_ch  = head_entry[ENTRY_W-1 -: CH_IDX_W];

  // Steer the response handshake to the head burst's channel; stall when nothing is tracked.
  always_comb begin
    ch_rsp_vld = '0;
    rsp_rdy    = 1'b0;
    if (!fifo_empty) begin
      ch_rsp_vld = rsp_vld ? (CH_NUM'(1) << head_ch) : '0;
      rsp_rdy    = ch_rsp_rdy[head_ch];
    end
  end

  assign ch_rsp_data = rsp_data;
  assign ch_rsp_last = rsp_last;

  assign beat_acc   = rsp_vld && rsp_rdy;
  assign burst_done = beat_acc && (beat_cnt == head_len);
  assign pop        = burst_done;

  // Illegal grants and last-flag disagreements with the beat count are both length errors.
  assign err_set = (issue_vld && !gnt_onehot) || (beat_acc && (rsp_last != burst_done));

  // Beat counter within the head burst; the burst terminates by count, not by rsp_last.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt <= '0;
    end else if (burst_done) begin
      beat_cnt <= '0;
    end else if (beat_acc) begin
      beat_cnt <= beat_cnt + LEN_W'(1);
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_len <= 1'b0;
    end else if (err_set) begin
      err_len <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dma_rsp_router.sv
// Directed bench for dma_rsp_router with hand-computed expectations.
module tb_dma_rsp_router;

  localparam int unsigned CH_NUM = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic              issue_vld;
  logic [CH_NUM-1:0] issue_gnt;
  logic [LEN_W-1:0]  issue_len;
  logic              issue_rdy;
  logic              rsp_vld;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic              rsp_rdy;
  logic [CH_NUM-1:0] ch_rsp_vld;
  logic [DATA_W-1:0] ch_rsp_data;
  logic              ch_rsp_last;
  logic [CH_NUM-1:0] ch_rsp_rdy;
  logic              err_len;
  logic [3:0]        outstanding;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dma_rsp_router #(
    .CH_NUM (CH_NUM),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .issue_vld   (issue_vld),
    .issue_gnt   (issue_gnt),
    .issue_len   (issue_len),
    .issue_rdy   (issue_rdy),
    .rsp_vld     (rsp_vld),
    .rsp_data    (rsp_data),
    .rsp_last    (rsp_last),
    .rsp_rdy     (rsp_rdy),
    .ch_rsp_vld  (ch_rsp_vld),
    .ch_rsp_data (ch_rsp_data),
    .ch_rsp_last (ch_rsp_last),
    .ch_rsp_rdy  (ch_rsp_rdy),
    .err_len     (err_len),
    .outstanding (outstanding)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic issue(input logic [3:0] gnt, input logic [7:0] len);
    issue_vld = 1'b1;
    issue_gnt = gnt;
    issue_len = len;
    tick();
    issue_vld = 1'b0;
    issue_gnt = '0;
    issue_len = '0;
    settle();
  endtask

  initial begin
    logic [3:0] exp_ch [8];

    rstn       = 1'b0;
    issue_vld  = 1'b0;
    issue_gnt  = '0;
    issue_len  = '0;
    rsp_vld    = 1'b0;
    rsp_data   = '0;
    rsp_last   = 1'b0;
    ch_rsp_rdy = 4'hF;
    tick();
    tick();
    chk("rst_issue_rdy", 32'(issue_rdy), 32'd1);
    chk("rst_rsp_rdy", 32'(rsp_rdy), 32'd0);
    chk("rst_ch_vld", 32'(ch_rsp_vld), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_err_len", 32'(err_len), 32'd0);
    rstn = 1'b1;
    tick();

    // ch2, 4 beats, last on beat 4
    issue(4'b0100, 8'd3);
    chk("t1_outstanding_1", 32'(outstanding), 32'd1);
    rsp_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rsp_data = 32'hA000_0000 + 32'(i);
      rsp_last = (i == 3);
      settle();
      chk("t1_ch_vld", 32'(ch_rsp_vld), 32'h4);
      chk("t1_rsp_rdy", 32'(rsp_rdy), 32'd1);
      chk("t1_data", ch_rsp_data, 32'hA000_0000 + 32'(i));
      chk("t1_last", 32'(ch_rsp_last), (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    rsp_vld = 1'b0;
    rsp_last = 1'b0;
    settle();
    chk("t1_outstanding_0", 32'(outstanding), 32'd0);
    chk("t1_err_len", 32'(err_len), 32'd0);

    // ch0 len0 then ch3 len1, back-to-back
    issue_vld = 1'b1; issue_gnt = 4'b0001; issue_len = 8'd0;
    tick();
    issue_gnt = 4'b1000; issue_len = 8'd1;
    tick();
    issue_vld = 1'b0; issue_gnt = '0; issue_len = '0;
    settle();
    chk("t2_outstanding_2", 32'(outstanding), 32'd2);
    rsp_vld = 1'b1;
    rsp_last = 1'b1; settle();
    chk("t2_beat1_ch0", 32'(ch_rsp_vld), 32'h1);
    tick();
    rsp_last = 1'b0; settle();
    chk("t2_beat2_ch3", 32'(ch_rsp_vld), 32'h8);
    tick();
    rsp_last = 1'b1; settle();
    chk("t2_beat3_ch3", 32'(ch_rsp_vld), 32'h8);
    tick();
    rsp_vld = 1'b0; rsp_last = 1'b0; settle();
    chk("t2_outstanding_0", 32'(outstanding), 32'd0);
    chk("t2_err_len", 32'(err_len), 32'd0);

    // stray beat while empty, then ch1 len0
    rsp_vld = 1'b1; rsp_last = 1'b1; rsp_data = 32'h5555_AAAA;
    settle();
    chk("t3_empty_rsp_rdy", 32'(rsp_rdy), 32'd0);
    chk("t3_empty_ch_vld", 32'(ch_rsp_vld), 32'd0);
    tick();
    chk("t3_empty_rsp_rdy_held", 32'(rsp_rdy), 32'd0);
    issue_vld = 1'b1; issue_gnt = 4'b0010; issue_len = 8'd0;
    settle();
    chk("t3_no_bypass", 32'(rsp_rdy), 32'd0);
    tick();
    issue_vld = 1'b0; issue_gnt = '0;
    settle();
    chk("t3_ch1_vld", 32'(ch_rsp_vld), 32'h2);
    chk("t3_ch1_rsp_rdy", 32'(rsp_rdy), 32'd1);
    chk("t3_ch1_data", ch_rsp_data, 32'h5555_AAAA);
    tick();
    rsp_vld = 1'b0; rsp_last = 1'b0; settle();
    chk("t3_outstanding_0", 32'(outstanding), 32'd0);

    // ch1 back-pressure for 5 cycles mid-burst
    issue(4'b0010, 8'd3);
    rsp_vld = 1'b1; rsp_data = 32'd100; settle();
    tick();
    ch_rsp_rdy = 4'b1101;
    rsp_data = 32'd101;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("t4_stall_rsp_rdy", 32'(rsp_rdy), 32'd0);
      chk("t4_stall_ch_vld", 32'(ch_rsp_vld), 32'h2);
      chk("t4_stall_beat_cnt", 32'(dut.beat_cnt), 32'd1);
      tick();
    end
    ch_rsp_rdy = 4'hF;
    for (int i = 1; i < 4; i++) begin
      rsp_data = 32'd100 + 32'(i);
      rsp_last = (i == 3);
      settle();
      chk("t4_resume_data", ch_rsp_data, 32'd100 + 32'(i));
      chk("t4_resume_beat_cnt", 32'(dut.beat_cnt), 32'(i));
      tick();
    end
    rsp_vld = 1'b0; rsp_last = 1'b0; settle();
    chk("t4_outstanding_0", 32'(outstanding), 32'd0);
    chk("t4_err_len", 32'(err_len), 32'd0);

    // fill to DEPTH, refuse extra, pop with simultaneous issue
    for (int i = 0; i < 8; i++) begin
      exp_ch[i] = 4'(1 << (i % 4));
      issue(exp_ch[i], 8'd0);
    end
    chk("t5_full_issue_rdy", 32'(issue_rdy), 32'd0);
    chk("t5_full_outstanding", 32'(outstanding), 32'd8);
    issue_vld = 1'b1; issue_gnt = 4'b0001; issue_len = 8'd0;
    tick();
    chk("t5_refused_outstanding", 32'(outstanding), 32'd8);
    rsp_vld = 1'b1; rsp_last = 1'b1;
    settle();
    chk("t5_pop_cycle_issue_rdy", 32'(issue_rdy), 32'd0);
    chk("t5_pop_cycle_ch_vld", 32'(ch_rsp_vld), 32'h1);
    tick();
    rsp_vld = 1'b0;
    settle();
    chk("t5_after_pop_outstanding", 32'(outstanding), 32'd7);
    chk("t5_after_pop_issue_rdy", 32'(issue_rdy), 32'd1);
    tick();
    issue_vld = 1'b0; issue_gnt = '0;
    settle();
    chk("t5_accepted_outstanding", 32'(outstanding), 32'd8);
    rsp_vld = 1'b1;
    for (int i = 1; i < 9; i++) begin
      settle();
      chk("t5_drain_ch", 32'(ch_rsp_vld), (i < 8) ? 32'(exp_ch[i]) : 32'h1);
      tick();
    end
    rsp_vld = 1'b0; rsp_last = 1'b0; settle();
    chk("t5_drained_outstanding", 32'(outstanding), 32'd0);

    // simultaneous push and pop keeps the count
    issue(4'b0100, 8'd0);
    issue_vld = 1'b1; issue_gnt = 4'b1000; issue_len = 8'd0;
    rsp_vld = 1'b1; rsp_last = 1'b1;
    settle();
    chk("t6_head_ch2", 32'(ch_rsp_vld), 32'h4);
    tick();
    issue_vld = 1'b0; issue_gnt = '0;
    settle();
    chk("t6_same_outstanding", 32'(outstanding), 32'd1);
    chk("t6_next_head_ch3", 32'(ch_rsp_vld), 32'h8);
    tick();
    rsp_vld = 1'b0; rsp_last = 1'b0; settle();
    chk("t6_outstanding_0", 32'(outstanding), 32'd0);
    chk("t6_err_len", 32'(err_len), 32'd0);

    // early last on beat 2 of a 4-beat burst
    issue(4'b0100, 8'd3);
    rsp_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rsp_last = (i == 1) || (i == 3);
      settle();
      chk("t7_ch_vld", 32'(ch_rsp_vld), 32'h4);
      tick();
      if (i == 0) chk("t7_err_before", 32'(err_len), 32'd0);
      if (i == 1) chk("t7_err_set", 32'(err_len), 32'd1);
      if (i == 2) chk("t7_still_tracked", 32'(outstanding), 32'd1);
    end
    rsp_vld = 1'b0; rsp_last = 1'b0; settle();
    chk("t7_outstanding_0", 32'(outstanding), 32'd0);
    chk("t7_err_sticky", 32'(err_len), 32'd1);

    // reset mid-burst clears state
    issue(4'b0001, 8'd3);
    rsp_vld = 1'b1; settle();
    tick();
    rstn = 1'b0;
    settle();
    chk("t8_rst_outstanding", 32'(outstanding), 32'd0);
    chk("t8_rst_err_len", 32'(err_len), 32'd0);
    chk("t8_rst_rsp_rdy", 32'(rsp_rdy), 32'd0);
    chk("t8_rst_issue_rdy", 32'(issue_rdy), 32'd1);
    chk("t8_rst_beat_cnt", 32'(dut.beat_cnt), 32'd0);
    rsp_vld = 1'b0;
    tick();
    rstn = 1'b1;
    tick();

    // illegal grants: no push, error flagged
    issue_vld = 1'b1; issue_gnt = 4'b0011; issue_len = 8'd0;
    settle();
    chk("t9_illegal_issue_rdy", 32'(issue_rdy), 32'd1);
    tick();
    issue_gnt = 4'b0000;
    tick();
    issue_vld = 1'b0;
    settle();
    chk("t9_illegal_outstanding", 32'(outstanding), 32'd0);
    chk("t9_illegal_err_len", 32'(err_len), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
